pong_match_ctrl: RTL and testbench
==================================

Name: pong_match_ctrl

Overview:
- Match-level controller for the pong game: sequences serve/play/point/game-over and owns both players' scores.
- Accepts one-cycle point events from the ball/collision logic; increments per-player two-digit BCD scores; gates ball motion; declares a winner.
- BCD score outputs feed the existing 4-digit seven-segment scan block directly (units/tens per player).

Parameters:
- WIN_SCORE, 11, points needed to win a game (1..99).
- HOLD_CYCLES, 50_000_000, clk cycles the ball stays frozen after a point before the next serve (≥1).
- CNT_W, 26, width of the hold counter; must hold HOLD_CYCLES-1.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  level/pulse; starts a match from IDLE or GAMEOVER
- point_p1  in  1  one-cycle pulse: player 1 scored
- point_p2  in  1  one-cycle pulse: player 2 scored
- score1units  out  4  player 1 units digit, BCD 0..9
- score1tens  out  4  player 1 tens digit, BCD 0..9
- score2units  out  4  player 2 units digit
- score2tens  out  4  player 2 tens digit
- ball_en  out  1  1 = ball may move (PLAY only)
- serve_dir  out  1  0 = serve toward player 1, 1 = toward player 2
- game_over  out  1  1 in GAMEOVER
- winner  out  1  0 = player 1, 1 = player 2; valid while game_over=1

Behaviour:
- Reset (async assert, synchronous-release by system): state IDLE, all score digits 0, ball_en 0, serve_dir 0, game_over 0, winner 0, hold counter 0. Reset mid-match discards everything.
- States: IDLE, SERVE, PLAY, HOLD, GAMEOVER. All outputs registered.
- IDLE: start=1 → SERVE next cycle; scores cleared on this transition.
- SERVE: single cycle; ball_en 0; → PLAY. Ball logic re-centres the ball on ball_en rising.
- PLAY: ball_en 1. Exactly one of point_p1/point_p2 high → increment that player's score (visible next cycle), serve_dir set toward the player who conceded (point_p1 → serve_dir=1), go to HOLD or GAMEOVER. Both high in the same cycle → ignored, stay PLAY.
- Point pulses outside PLAY are ignored.
- BCD increment: units 9 → 0 with tens+1; 99 saturates (unreachable with WIN_SCORE ≤ 99 but required).
- Win check uses post-increment value: 10*tens+units == WIN_SCORE → GAMEOVER, winner = scorer, game_over=1 one cycle after the point pulse; otherwise → HOLD.
- HOLD: ball_en 0; counter runs 0..HOLD_CYCLES-1, then → SERVE. HOLD lasts exactly HOLD_CYCLES cycles.
- GAMEOVER: scores frozen, ball_en 0; start=1 → SERVE with scores cleared, game_over 0, serve_dir 0.
- start is ignored in SERVE/PLAY/HOLD.

Optional Feature:
- Macro WIN_BY_TWO_EN.
- Defined: a game ends only when the scorer has ≥ WIN_SCORE and leads by ≥ 2; otherwise → HOLD. At 99 a player's score saturates and a 2-point lead then wins outright.
- Undefined: first to WIN_SCORE wins as above.

Decomposition:
- Shared package pong_pkg: state enum (IDLE, SERVE, PLAY, HOLD, GAMEOVER), default WIN_SCORE and HOLD_CYCLES constants, player-id encoding (P1=0, P2=1).
- One sub-module: bcd_cnt2, a two-digit BCD counter with clear/inc inputs, saturating at 99, and a binary value output for the win compare. Instantiate once per player.

Test Plan (HOLD_CYCLES=4, WIN_SCORE=11):
- reset_n low mid-PLAY with score 3-2 → all digits 0, ball_en 0, state IDLE immediately and independent of clk.
- start; point_p1 pulse in PLAY → score1units=1 next cycle, serve_dir=1, ball_en 0 for exactly 4 cycles, one SERVE cycle, then ball_en 1.
- Player 1 scores 10 points → score1tens=1, score1units=0 (carry correct); 11th point → game_over=1, winner=0, ball_en 0; scores remain 11-0 until start.
- point_p1 and point_p2 high in the same PLAY cycle → no score change, stays PLAY; pulses during HOLD/SERVE → no score change.
- In GAMEOVER, start → scores 00-00, game_over 0, SERVE then PLAY.
- With WIN_BY_TWO_EN: reach 10-10; P1 scores → 11-10, no game over; P1 scores → 12-10, game_over=1, winner=0.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and constants for the pong match controller and its score counters.
package pong_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StServe,
    StPlay,
    StHold,
    StGameOver
  } state_e;

  typedef enum logic {
    PlayerP1 = 1'b0,
    PlayerP2 = 1'b1
  } player_e;

  localparam int unsigned DefWinScore   = 11;
  localparam int unsigned DefHoldCycles = 50_000_000;
  localparam int unsigned DefCntW       = 26;

  localparam logic [3:0] BcdMax   = 4'd9;
  localparam logic [6:0] MaxScore = 7'd99;

  // Binary score after one point, saturating at 99 like the BCD counters.
  function automatic logic [6:0] sat_inc(input logic [6:0] v);
    return (v >= MaxScore) ? MaxScore : v + 7'd1;
  endfunction

endpackage

// File: rtl/bcd_cnt2.sv
// Two-digit BCD score counter with synchronous clear/increment, saturating at 99,
// plus a binary view of the current value for win comparison.
module bcd_cnt2
  import pong_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       inc_i,
  output logic [3:0] units_o,
  output logic [3:0] tens_o,
  output logic [6:0] value_o
);

  logic [3:0] units_d, units_q;
  logic [3:0] tens_d, tens_q;

  always_comb begin
    units_d = units_q;
    tens_d  = tens_q;
    if (clr_i) begin
      units_d = '0;
      tens_d  = '0;
    end else if (inc_i) begin
      if (units_q != BcdMax) begin
        units_d = units_q + 4'd1;
      end else if (tens_q != BcdMax) begin
        units_d = '0;
        tens_d  = tens_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      units_q <= '0;
      tens_q  <= '0;
    end else begin
      units_q <= units_d;
      tens_q  <= tens_d;
    end
  end

  assign units_o = units_q;
  assign tens_o  = tens_q;
  assign value_o = {3'b000, tens_q} * 7'd10 + {3'b000, units_q};

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve/play/hold/game-over, per-player BCD scores, winner.
// Build option WIN_BY_TWO_EN: a game needs WIN_SCORE and a lead of at least two.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE   = DefWinScore,
  parameter int unsigned HOLD_CYCLES = DefHoldCycles,
  parameter int unsigned CNT_W       = DefCntW
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       point_p1,
  input  logic       point_p2,
  output logic [3:0] score1units,
  output logic [3:0] score1tens,
  output logic [3:0] score2units,
  output logic [3:0] score2tens,
  output logic       ball_en,
  output logic       serve_dir,
  output logic       game_over,
  output logic       winner
);

  localparam logic [6:0]       WinScore = 7'(WIN_SCORE);
  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(HOLD_CYCLES - 1);

  state_e           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             ball_en_d, ball_en_q;
  logic             serve_dir_d, serve_dir_q;
  logic             game_over_d, game_over_q;
  logic             winner_d, winner_q;
  logic             clr_scores, inc1, inc2;
  logic [6:0]       val1, val2, scorer_new;
  logic             one_point, win;

  assign one_point  = point_p1 ^ point_p2;
  assign scorer_new = point_p1 ? sat_inc(val1) : sat_inc(val2);

`ifdef WIN_BY_TWO_EN
  logic [6:0] other_val;
  assign other_val = point_p1 ? val2 : val1;
  assign win = (scorer_new >= WinScore) &&
               ({1'b0, scorer_new} >= ({1'b0, other_val} + 8'd2));
`else
  assign win = (scorer_new == WinScore);
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    serve_dir_d = serve_dir_q;
    game_over_d = game_over_q;
    winner_d    = winner_q;
    clr_scores  = 1'b0;
    inc1        = 1'b0;
    inc2        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StServe;
          clr_scores  = 1'b1;
          serve_dir_d = 1'b0;
        end
      end
      StServe: state_d = StPlay;
      StPlay: begin
        if (one_point) begin
          inc1        = point_p1;
          inc2        = point_p2;
          // Next serve goes toward the player who conceded.
          serve_dir_d = point_p1;
          if (win) begin
            state_d     = StGameOver;
            game_over_d = 1'b1;
            winner_d    = point_p1 ? PlayerP1 : PlayerP2;
          end else begin
            state_d = StHold;
            cnt_d   = '0;
          end
        end
      end
      StHold: begin
        if (cnt_q == HoldLast) begin
          state_d = StServe;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StGameOver: begin
        if (start) begin
          state_d     = StServe;
          clr_scores  = 1'b1;
          game_over_d = 1'b0;
          serve_dir_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    ball_en_d = (state_d == StPlay);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      ball_en_q   <= 1'b0;
      serve_dir_q <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ball_en_q   <= ball_en_d;
      serve_dir_q <= serve_dir_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
    end
  end

  bcd_cnt2 u_score1 (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .clr_i   (clr_scores),
    .inc_i   (inc1),
    .units_o (score1units),
    .tens_o  (score1tens),
    .value_o (val1)
  );

  bcd_cnt2 u_score2 (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .clr_i   (clr_scores),
    .inc_i   (inc2),
    .units_o (score2units),
    .tens_o  (score2tens),
    .value_o (val2)
  );

  assign ball_en   = ball_en_q;
  assign serve_dir = serve_dir_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Scoreboard bench for pong_match_ctrl with HOLD_CYCLES=4, WIN_SCORE=11.
module tb_pong_match_ctrl;

  logic       clk = 1'b0;
  logic       reset_n, start, point_p1, point_p2;
  logic [3:0] s1u, s1t, s2u, s2t;
  logic       ball_en, serve_dir, game_over, winner;

  always #5 clk = ~clk;

  pong_match_ctrl #(
    .WIN_SCORE   (11),
    .HOLD_CYCLES (4),
    .CNT_W       (3)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .point_p1    (point_p1),
    .point_p2    (point_p2),
    .score1units (s1u),
    .score1tens  (s1t),
    .score2units (s2u),
    .score2tens  (s2t),
    .ball_en     (ball_en),
    .serve_dir   (serve_dir),
    .game_over   (game_over),
    .winner      (winner)
  );

  typedef struct packed {
    logic [6:0] s1;
    logic [6:0] s2;
    logic       be;
    logic       sd;
    logic       go;
    logic       w;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   e1, e2;
  logic esd, ego, ew;

  function automatic void chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  function automatic void check_outputs(input exp_t e);
    chk("score1units", int'(s1u), int'(e.s1) % 10);
    chk("score1tens", int'(s1t), int'(e.s1) / 10);
    chk("score2units", int'(s2u), int'(e.s2) % 10);
    chk("score2tens", int'(s2t), int'(e.s2) / 10);
    chk("ball_en", int'(ball_en), int'(e.be));
    chk("serve_dir", int'(serve_dir), int'(e.sd));
    chk("game_over", int'(game_over), int'(e.go));
    if (e.go) chk("winner", int'(winner), int'(e.w));
  endfunction

  // Monitor: each queued expectation describes the outputs after the next clock edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check_outputs(mon_e);
    end
  end

  task automatic step(input logic st, input logic a, input logic b, input logic be);
    exp_t e;
    @(negedge clk);
    #1;
    start    = st;
    point_p1 = a;
    point_p2 = b;
    e.s1 = 7'(e1);
    e.s2 = 7'(e2);
    e.be = be;
    e.sd = esd;
    e.go = ego;
    e.w  = ew;
    exp_q.push_back(e);
  endtask

  // One point in PLAY; then HOLD(4) + SERVE(1) with stray pulses/start, or frozen GAMEOVER.
  task automatic point(input bit p2, input bit win);
    if (p2) begin
      e2++;
      esd = 1'b0;
    end else begin
      e1++;
      esd = 1'b1;
    end
    if (win) begin
      ego = 1'b1;
      ew  = p2;
    end
    step(1'b0, !p2, p2, 1'b0);
    if (win) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
    end else begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b1);
    end
  endtask

  task automatic restart();
    e1 = 0;
    e2 = 0;
    esd = 1'b0;
    ego = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    reset_n = 1'b1;
    start = 1'b0;
    point_p1 = 1'b0;
    point_p2 = 1'b0;
    e1 = 0;
    e2 = 0;
    esd = 1'b0;
    ego = 1'b0;
    ew = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_ball_en", int'(ball_en), 0);
    chk("rst_game_over", int'(game_over), 0);
    chk("rst_score1", int'({s1t, s1u}), 0);
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;

    step(1'b0, 1'b0, 1'b0, 1'b0);
    restart();
    point(1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    point(1'b1, 1'b0);
    repeat (9) point(1'b0, 1'b0);
    point(1'b0, 1'b1);

    restart();
    for (int i = 0; i < 10; i++) begin
      point(1'b0, 1'b0);
      point(1'b1, 1'b0);
    end
`ifdef WIN_BY_TWO_EN
    point(1'b0, 1'b0);
    point(1'b0, 1'b1);
`else
    point(1'b1, 1'b1);
`endif

    restart();
    point(1'b1, 1'b0);
    point(1'b1, 1'b0);
    point(1'b0, 1'b0);
    point(1'b0, 1'b0);
    point(1'b0, 1'b0);

    // Asynchronous reset in PLAY at 3-2, between clock edges.
    @(negedge clk);
    #1;
    start = 1'b0;
    point_p1 = 1'b0;
    point_p2 = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("arst_score1", int'({s1t, s1u}), 0);
    chk("arst_score2", int'({s2t, s2u}), 0);
    chk("arst_ball_en", int'(ball_en), 0);
    chk("arst_serve_dir", int'(serve_dir), 0);
    chk("arst_game_over", int'(game_over), 0);
    e1 = 0;
    e2 = 0;
    esd = 1'b0;
    ego = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
